conv_32_8: RTL
==============

Name: conv_32_8

Overview:
- Serializer from 32-bit words to 8-bit bytes; the transmit-side counterpart of the 8-to-32 byte-packing converter.
- Accepts one 32-bit word per valid/ready handshake and emits it as four consecutive bytes, MSB first by default, each qualified by valid_out.
- Holds one word in a holding register, so back-to-back words stream gaplessly at one byte per cycle.
- Sits in the bit-handling (Manejo_bits) path, feeding byte-wide links whose receiver packs bytes back into words.

Parameters:
- MSB_FIRST, 1: 1 = byte order [31:24],[23:16],[15:8],[7:0]; 0 = reverse order ([7:0] first).

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in is valid this cycle.
- data_in  input  32  word to serialize.
- ready_in  output  1  block can accept a word this cycle.
- data_out  output  8  current byte.
- valid_out  output  1  data_out is valid.
- last_out  output  1  data_out is the 4th (final) byte of its word.

Behaviour:
- One clock (clk); reset_L asynchronous active-low. Assertion immediately forces:
  - data_out=8'h00, valid_out=0, last_out=0;
  - byte counter cnt=0, active word cleared, holding register empty (hold_v=0).
- Release is sampled on the next rising edge.
- ready_in = ~hold_v. It is combinational from registered state only; no path from valid_in.
- A word is accepted on a rising edge where valid_in=1 and ready_in=1. With valid_in=1 and ready_in=0, the word is ignored; the source must hold it.
- All outputs are registered. When valid_out=0, data_out=8'h00 and last_out=0.
- The output slot is free on an edge when valid_out=0, or when valid_out=1 and cnt=3.
- States:
  - IDLE: valid_out=0.
  - SEND: valid_out=1; cnt = index (0..3) of the byte on data_out.
- At each rising edge, first matching rule applies:
  1. SEND and cnt<3: cnt<=cnt+1; data_out<=next byte of active word. Any accepted word goes to hold (hold_v<=1).
  2. Slot free and hold_v=1: load hold into active word; data_out<=byte 0; cnt<=0; valid_out<=1; hold_v<=0. ready_in was 0, so there is no simultaneous accept.
  3. Slot free, hold_v=0, word accepted: word goes straight to active word; data_out<=byte 0 of data_in; cnt<=0; valid_out<=1. Hold stays empty.
  4. Slot free, nothing pending: go to IDLE; valid_out<=0; data_out<=8'h00; cnt<=0.
- last_out<=1 exactly when the byte being loaded is byte 3 (cnt becomes 3).
- Latency: a word accepted at edge N in IDLE drives byte 0 after edge N, then bytes 1..3 after edges N+1..N+3.
- Throughput: one word per 4 cycles, with no idle cycles between words while inputs keep up.
- Byte k: for MSB_FIRST=1, byte k = word[31-8k -: 8]; for MSB_FIRST=0, byte k = word[8k +: 8].
- No output backpressure; the downstream must take every valid byte.
- cnt is 2 bits and wraps 3->0 only through rules 2-4; it never exceeds 3.
- Reset mid-word discards the active and held words; no partial-word completion after release.
- When valid_in deasserts mid-word, the current word still finishes all 4 bytes.

Test Plan:
- Reset check: reset_L=0 during active SEND -> same cycle data_out=00, valid_out=0, last_out=0, ready_in=1. After release, no further bytes.
- Single word: MSB_FIRST=1, accept 32'hA1B2C3D4 from IDLE -> data_out A1,B2,C3,D4 on 4 consecutive cycles, valid_out=1 throughout, last_out=1 only with D4, then valid_out=0, data_out=00.
- Reverse order: MSB_FIRST=0, accept 32'h11223344 -> bytes 44,33,22,11.
- Back-to-back: valid_in held 1 with 32'h01020304 then 32'h05060708 as soon as each is accepted -> second word enters hold and ready_in=0 until its load. Output 01..04 immediately followed by 05..08 with no gap; last_out pulses on 04 and 08.
- Backpressure: present a third word 32'hDEADBEEF while hold is full -> not accepted until ready_in returns to 1. Appears once, in order, with no byte lost or duplicated.
- Boundary simultaneous: hold empty, valid_in arrives on the edge where cnt=3 -> new word's byte 0 follows the previous byte 3 on the next cycle (rule 3), with hold_v remaining 0.

Source files
------------

// File: rtl/conv_32_8.sv
// 32-bit word to 8-bit byte serializer with a one-word holding register,
// so back-to-back words stream out at one byte per cycle with no gaps.
module conv_32_8 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        reset_L,
   input  logic        valid_in,
   input  logic [31:0] data_in,
   output logic        ready_in,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        last_out
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic [31:0] r_word;
   logic [31:0] r_hold;
   logic        r_hold_v;
   logic [7:0]  r_data;
   logic        r_last;
   logic        w_accept;

   function automatic logic [7:0] f_byte(input logic [31:0] w, input logic [1:0] k);
      logic [1:0] idx;
      logic [7:0] b;
      idx = MSB_FIRST ? (2'd3 - k) : k;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   // ready depends only on the holding register, never on valid_in
   assign ready_in  = ~r_hold_v;
   assign w_accept  = valid_in & ~r_hold_v;
   assign data_out  = r_data;
   assign last_out  = r_last;
   assign valid_out = (r_state == SEND);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_word   <= 32'h0;
         r_hold   <= 32'h0;
         r_hold_v <= 1'b0;
         r_data   <= 8'h00;
         r_last   <= 1'b0;
      end else if (r_state == SEND && r_cnt != 2'd3) begin
         r_cnt  <= r_cnt + 2'd1;
         r_data <= f_byte(r_word, r_cnt + 2'd1);
         r_last <= (r_cnt == 2'd2);
         if (w_accept) begin
            r_hold   <= data_in;
            r_hold_v <= 1'b1;
         end
      end else if (r_hold_v) begin
         // output slot is free here: IDLE, or the last byte is leaving
         r_word   <= r_hold;
         r_data   <= f_byte(r_hold, 2'd0);
         r_cnt    <= 2'd0;
         r_last   <= 1'b0;
         r_state  <= SEND;
         r_hold_v <= 1'b0;
      end else if (w_accept) begin
         r_word  <= data_in;
         r_data  <= f_byte(data_in, 2'd0);
         r_cnt   <= 2'd0;
         r_last  <= 1'b0;
         r_state <= SEND;
      end else begin
         r_state <= IDLE;
         r_data  <= 8'h00;
         r_cnt   <= 2'd0;
         r_last  <= 1'b0;
      end
   end

endmodule
